// File: rtl/cmd_pkg.sv
// Shared constants, serializer state type and hex-digit encoder for the command transmitter.
package cmd_pkg;

    localparam int         DEF_DIV  = 104;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] nib2asc(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serializer: start bit, 8 data bits LSB first, stop bit, each held DIV cycles.
// Latency: tx drops on the cycle after load; stop_end flags the final stop-bit cycle.
// Backpressure: load is honoured only while idle or on stop_end, otherwise ignored.
module uart_tx_byte
    import cmd_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_dat,
    output logic       rdy,
    output logic       stop_end,
    output logic       tx
);

    localparam int            BW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(DIV - 1);

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_MAX);
    assign rdy      = (state_q == ST_IDLE);
    assign stop_end = (state_q == ST_STOP) && baud_end;
    assign tx       = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is computed one cycle ahead so the line comes straight off a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (load) begin
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    sh_d    = byte_dat;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_d = ST_DATA;
                    tx_d    = sh_q[0];
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = {1'b0, sh_q[7:1]};
                        tx_d  = sh_q[1];
                    end
                end
            end
            ST_STOP: begin
                // A load here chains the next start bit with no idle gap.
                if (baud_end) begin
                    if (load) begin
                        state_d = ST_START;
                        tx_d    = 1'b0;
                        sh_d    = byte_dat;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/cmd_tx.sv
// Command transmitter: sends 'S' plus three ASCII hex digits of DATA (plus CR when CMD_TX_CR_EN).
// Latency: TX falls the cycle after acceptance; DONE pulses 10*DIV cycles per character later.
// Backpressure: READY low while sending; VALID without READY is dropped, never queued.
module cmd_tx
    import cmd_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        VALID,
    input  logic [11:0] DATA,
    output logic        READY,
    output logic        DONE,
    output logic        TX
);

`ifdef CMD_TX_CR_EN
    localparam int NCHAR = 5;
`else
    localparam int NCHAR = 4;
`endif
    localparam int            IW       = $clog2(NCHAR);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHAR - 1);

    logic [11:0]   hold_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_nxt;
    logic          busy_q;
    logic          done_q;
    logic          accept;
    logic          ser_load;
    logic          ser_rdy;
    logic          ser_stop_end;
    logic [7:0]    ser_dat;
    logic [7:0]    next_char;

    assign READY   = !busy_q && ser_rdy;
    assign DONE    = done_q;
    assign accept  = VALID && READY;
    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        next_char = ASCII_S;
        case (idx_nxt)
            IW'(1):  next_char = nib2asc(hold_q[11:8]);
            IW'(2):  next_char = nib2asc(hold_q[7:4]);
            IW'(3):  next_char = nib2asc(hold_q[3:0]);
`ifdef CMD_TX_CR_EN
            IW'(4):  next_char = ASCII_CR;
`endif
            default: next_char = ASCII_S;
        endcase
    end

    // The first character is always 'S', so it never needs the not-yet-captured DATA.
    assign ser_load = accept || (ser_stop_end && (idx_q != LAST_IDX));
    assign ser_dat  = accept ? ASCII_S : next_char;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                hold_q <= DATA;
                idx_q  <= '0;
                busy_q <= 1'b1;
            end else if (ser_stop_end) begin
                if (idx_q == LAST_IDX) begin
                    idx_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    idx_q <= idx_nxt;
                end
            end
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_ser (
        .clk      (CLK),
        .rst      (RST),
        .load     (ser_load),
        .byte_dat (ser_dat),
        .rdy      (ser_rdy),
        .stop_end (ser_stop_end),
        .tx       (TX)
    );

endmodule

// File: doc/cmd_tx.md
CMD_TX -- requirements
Module: cmd_tx

Interface
REQ-001 Parameter DIV, default 104, clock cycles per UART bit (12 MHz / 115200 baud).
REQ-002 CLK  input  1  system clock, 12 MHz nominal; all logic on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 VALID  input  1  command request; qualifies DATA.
REQ-005 DATA  input  12  command argument, sent as three hex digits.
REQ-006 READY  output  1  high when idle and able to accept a command.
REQ-007 DONE  output  1  one-cycle pulse when the last stop bit completes.
REQ-008 TX  output  1  UART serial line, idle high.

Function
REQ-009 Handshake: command accepted on a rising edge with VALID=1 and READY=1; DATA captured into a 12-bit holding register; READY low from the next cycle.
REQ-010 VALID while READY=0 shall be ignored, with no queuing and no effect on the transfer in progress.
REQ-011 Transmitted sequence shall be 'S' (0x53), then ASCII hex of DATA[11:8], DATA[7:4], DATA[3:0].
REQ-012 Hex encoding: 0-9 -> 0x30-0x39; A-F -> uppercase 0x41-0x46.
REQ-013 Each character frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); every bit held exactly DIV cycles.
REQ-014 Characters back-to-back: next start bit begins the cycle after the previous stop bit ends, with no idle gap.
REQ-015 Latency: TX falls to 0 on the cycle after acceptance.
REQ-016 Duration: acceptance to DONE is exactly 4*10*DIV cycles (4160 at default).
REQ-017 FSM states IDLE, START, DATA, STOP; counters: baud 0..DIV-1, bit 0..7, character index 0..3.
REQ-018 Transitions: IDLE->START on accept; START->DATA after DIV; DATA->STOP after 8 bits; STOP->START if more characters remain, else STOP->IDLE.
REQ-019 On STOP->IDLE: DONE=1 for exactly one cycle, READY=1 in the same cycle.
REQ-020 VALID=1 in the cycle DONE=1 shall be accepted, giving back-to-back commands separated only by that cycle.
REQ-021 The baud counter shall wrap at DIV-1 without overflow; a 1-bit change of DIV shall change only bit length.
REQ-022 TX shall be driven from a register, glitch-free.

Reset
REQ-023 With RST=1: TX=1, READY=1, DONE=0, FSM=IDLE, all counters 0, holding register 0.
REQ-024 RST asserted mid-frame shall abort the transfer: TX=1 and READY=1 on the next edge, with no DONE pulse.
REQ-025 RST shall have priority over VALID in the same cycle.

Configuration
REQ-026 Macro CMD_TX_CR_EN defined: a fifth character, carriage return 0x0D, is sent after the last hex digit; index range 0..4; duration 5*10*DIV cycles.
REQ-027 Macro CMD_TX_CR_EN undefined: exactly four characters, with no CR logic present.

Structure
REQ-028 Shared package cmd_pkg shall hold: default DIV, ASCII constant for 'S' (and CR), FSM state enum, nibble-to-ASCII function.
REQ-029 One sub-module, uart_tx_byte, shall implement the byte serializer (start/data/stop, baud counter), and cmd_tx shall sequence the characters.

Verification
REQ-030 DATA=0x0F7, sampling TX at mid-bit -> bytes 0x53,0x30,0x46,0x37; DONE exactly 4160 cycles after acceptance.
REQ-031 DATA=0x114 -> bytes 0x53,0x31,0x31,0x34; then DATA=0xABC offered in the DONE cycle -> bytes 0x53,0x41,0x42,0x43 with no gap beyond 1 cycle.
REQ-032 VALID pulsed with DATA=0x555 at cycle 1000 of a 0x0F7 transfer -> output unchanged from REQ-030, and no second command.
REQ-033 RST for 1 cycle during bit 3 of the second character -> TX=1 next cycle, READY=1, no DONE; a new 0x000 command then gives 0x53,0x30,0x30,0x30.
REQ-034 With CMD_TX_CR_EN, DATA=0xFFF -> bytes 0x53,0x46,0x46,0x46,0x0D; DONE after 5200 cycles.
